// File: rtl/replay_sequencer_if.sv
// Bundle of the serial-data stream, buffer write/read and replay handshake signals
// shared by the replay sequencer and whatever feeds and consumes it.
interface replay_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              record_en;
    logic              record_we;
    logic [ADDR_W-1:0] record_addr;
    logic              overflow;
    logic              replay_start;
    logic              replay_en;
    logic [ADDR_W-1:0] replay_addr;
    logic              replay_last;
    logic              replay_ack;
    logic              done;
    logic [ADDR_W:0]   length;

    modport master (
        output ready, data, replay_ack,
        input  record_en, record_we, record_addr, overflow, replay_start,
               replay_en, replay_addr, replay_last, done, length
    );

    modport slave (
        input  ready, data, replay_ack,
        output record_en, record_we, record_addr, overflow, replay_start,
               replay_en, replay_addr, replay_last, done, length
    );
endinterface

// File: rtl/replay_sequencer.sv
// Record/replay controller: records non-marker words into an external buffer, replays
// them on START_MARK (once or looping) and re-arms recording on STOP_MARK.
module replay_sequencer #(
    parameter int                 DATA_W     = 8,
    parameter int                 ADDR_W     = 6,
    parameter logic [DATA_W-1:0]  START_MARK = DATA_W'(8'h30),
    parameter logic [DATA_W-1:0]  STOP_MARK  = DATA_W'(8'h31),
    parameter int                 LOOP       = 0
) (
    input logic               clk,
    input logic               rst,
    replay_sequencer_if.slave bus
);

    typedef enum logic [1:0] {RECORD, START, REPLAY, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W:0]   length, length_n;
    logic              overflow, overflow_n;
    logic [ADDR_W-1:0] replay_addr, replay_addr_n;

    logic is_start, is_stop, is_word, full, at_last, we;

    always_comb begin
        is_start = bus.ready && (bus.data == START_MARK);
        is_stop  = bus.ready && (bus.data == STOP_MARK);
        is_word  = bus.ready && !is_start && !is_stop;
        // length == 2^ADDR_W is the only value with the top bit set
        full     = length[ADDR_W];
        at_last  = ({1'b0, replay_addr} == (length - 1'b1));
        we       = !rst && (state == RECORD) && is_word && !full;
    end

    always_comb begin
        state_n       = state;
        length_n      = length;
        overflow_n    = overflow;
        replay_addr_n = replay_addr;
        case (state)
            RECORD: begin
                if (we)
                    length_n = length + 1'b1;
                else if (is_word && full)
                    overflow_n = 1'b1;
                if (is_start && (length != '0))
                    state_n = START;
            end
            START: begin
                replay_addr_n = '0;
                state_n       = REPLAY;
            end
            REPLAY: begin
                if (bus.replay_ack) begin
                    if (!at_last)
                        replay_addr_n = replay_addr + 1'b1;
                    else if (LOOP != 0)
                        replay_addr_n = '0;
                    else
                        state_n = DONE;
                end
            end
            default: ;
        endcase
        // STOP wins over a same-cycle ack and wipes the previous take
        if ((state != RECORD) && is_stop) begin
            state_n       = RECORD;
            length_n      = '0;
            overflow_n    = 1'b0;
            replay_addr_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RECORD;
            length      <= '0;
            overflow    <= 1'b0;
            replay_addr <= '0;
        end else begin
            state       <= state_n;
            length      <= length_n;
            overflow    <= overflow_n;
            replay_addr <= replay_addr_n;
        end
    end

    assign bus.record_en    = (state == RECORD);
    assign bus.record_we    = we;
    assign bus.record_addr  = length[ADDR_W-1:0];
    assign bus.overflow     = overflow;
    assign bus.replay_start = (state == START);
    assign bus.replay_en    = (state == REPLAY);
    assign bus.replay_addr  = replay_addr;
    assign bus.replay_last  = (state == REPLAY) && at_last;
    assign bus.done         = (state == DONE);
    assign bus.length       = length;

endmodule

// File: tb/tb_replay_sequencer.sv
// Scoreboard bench: dut_a (ADDR_W=6, one-shot) and dut_b (ADDR_W=2, looping) share stimulus;
// sel picks which one the monitor and checks look at.
module tb_replay_sequencer;

    localparam logic [7:0] S_MARK = 8'h30;
    localparam logic [7:0] P_MARK = 8'h31;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data = '0;
    logic       ack = 1'b0;
    logic       sel = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    int exp_wr[$];
    int exp_rd[$];
    int m_len = 0;
    int cap = 64;
    int start_cnt = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    replay_sequencer_if #(.DATA_W(8), .ADDR_W(6)) bus_a ();
    replay_sequencer_if #(.DATA_W(8), .ADDR_W(2)) bus_b ();

    assign bus_a.ready = ready;
    assign bus_a.data = data;
    assign bus_a.replay_ack = ack;
    assign bus_b.ready = ready;
    assign bus_b.data = data;
    assign bus_b.replay_ack = ack;

    replay_sequencer #(.DATA_W(8), .ADDR_W(6), .LOOP(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    replay_sequencer #(.DATA_W(8), .ADDR_W(2), .LOOP(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    logic       m_ren, m_we, m_ovf, m_start, m_en, m_last, m_done;
    logic [5:0] m_waddr, m_raddr;
    logic [6:0] m_len_o;

    always_comb begin
        if (!sel) begin
            m_ren = bus_a.record_en;  m_we = bus_a.record_we;  m_waddr = bus_a.record_addr;
            m_ovf = bus_a.overflow;   m_start = bus_a.replay_start; m_en = bus_a.replay_en;
            m_raddr = bus_a.replay_addr; m_last = bus_a.replay_last; m_done = bus_a.done;
            m_len_o = bus_a.length;
        end else begin
            m_ren = bus_b.record_en;  m_we = bus_b.record_we;  m_waddr = {4'b0, bus_b.record_addr};
            m_ovf = bus_b.overflow;   m_start = bus_b.replay_start; m_en = bus_b.replay_en;
            m_raddr = {4'b0, bus_b.replay_addr}; m_last = bus_b.replay_last; m_done = bus_b.done;
            m_len_o = {4'b0, bus_b.length};
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Writes and acked reads are popped against what the stimulus predicted.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_we) begin
                if (exp_wr.size() == 0) chk("wr_unexpected", int'(m_waddr) * 256 + int'(data), -1);
                else chk("wr", int'(m_waddr) * 256 + int'(data), exp_wr.pop_front());
            end
            if (m_en && ack && !(ready && data == P_MARK)) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", int'(m_raddr) * 2 + int'(m_last), -1);
                else chk("rd", int'(m_raddr) * 2 + int'(m_last), exp_rd.pop_front());
            end
            if (m_start) start_cnt++;
            if (m_done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        ready = 1'b1;
        data = d;
        tick();
        ready = 1'b0;
        tick();
    endtask

    task automatic rec(input logic [7:0] d);
        if (m_len < cap) begin
            exp_wr.push_back(m_len * 256 + int'(d));
            m_len++;
        end
        send(d);
    endtask

    task automatic start_replay(input string tag);
        ready = 1'b1;
        data = S_MARK;
        tick();
        ready = 1'b0;
        chk({tag, "_start_pulse"}, m_start, 1);
        chk({tag, "_rec_en_low"}, m_ren, 0);
        tick();
        chk({tag, "_start_gone"}, m_start, 0);
        chk({tag, "_replay_en"}, m_en, 1);
        chk({tag, "_raddr0"}, m_raddr, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rec_en"}, m_ren, 1);
        chk({tag, "_we"}, m_we, 0);
        chk({tag, "_waddr"}, m_waddr, 0);
        chk({tag, "_ovf"}, m_ovf, 0);
        chk({tag, "_start"}, m_start, 0);
        chk({tag, "_replay_en"}, m_en, 0);
        chk({tag, "_raddr"}, m_raddr, 0);
        chk({tag, "_last"}, m_last, 0);
        chk({tag, "_done"}, m_done, 0);
        chk({tag, "_len"}, m_len_o, 0);
    endtask

    task automatic ack_n(input int n);
        ack = 1'b1;
        repeat (n) tick();
        ack = 1'b0;
    endtask

    initial begin
        int sc;
        // ---- one-shot DUT ----
        tick(); tick();
        rst = 1'b0;
        chk_reset("rst");

        sc = start_cnt;
        send(S_MARK);
        chk("empty_start_pulse", start_cnt, sc);
        chk("empty_rec_en", m_ren, 1);
        send(P_MARK);
        chk("stop_in_rec_len", m_len_o, 0);

        rec("a"); tick(); rec("b"); tick(); rec("c");
        chk("basic_len", m_len_o, 3);
        start_replay("basic");
        exp_rd.push_back(0); exp_rd.push_back(2); exp_rd.push_back(5);
        ack_n(3);
        chk("basic_done", m_done, 1);
        chk("basic_replay_off", m_en, 0);
        chk("basic_addr_held", m_raddr, 2);
        send("x"); send(S_MARK);
        chk("done_filter", m_done, 1);
        send(P_MARK);
        m_len = 0;
        chk("rearm_done_rec", m_ren, 1);
        chk("rearm_done_len", m_len_o, 0);

        rec("p"); rec("q"); rec("r"); rec("s");
        start_replay("rearm");
        exp_rd.push_back(0); exp_rd.push_back(2);
        ack_n(2);
        send(S_MARK); send("x");
        chk("filter_replay_en", m_en, 1);
        chk("filter_addr", m_raddr, 2);
        chk("filter_len", m_len_o, 4);
        ready = 1'b1; data = P_MARK; ack = 1'b1;
        tick();
        ready = 1'b0; ack = 1'b0;
        m_len = 0;
        chk("stop_ack_rec", m_ren, 1);
        chk("stop_ack_len", m_len_o, 0);
        chk("stop_ack_ovf", m_ovf, 0);
        chk("stop_ack_addr", m_raddr, 0);
        rec("m"); rec("n");
        start_replay("rearm2");
        exp_rd.push_back(0); exp_rd.push_back(3);
        ack_n(2);
        chk("rearm2_done", m_done, 1);
        send(P_MARK);
        m_len = 0;

        rec("g"); rec("h"); rec("i");
        start_replay("midrst");
        exp_rd.push_back(0);
        ack = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; ack = 1'b0;
        m_len = 0;
        chk_reset("midrst");
        rec("u"); rec("v");
        start_replay("after_rst");
        exp_rd.push_back(0); exp_rd.push_back(3);
        ack_n(2);
        chk("after_rst_done", m_done, 1);

        // ---- looping DUT, 4-word buffer ----
        sel = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        m_len = 0; cap = 4;
        chk_reset("b_rst");
        for (int i = 0; i < 6; i++) rec(8'h41 + 8'(i));
        chk("full_ovf", m_ovf, 1);
        chk("full_len", m_len_o, 4);
        start_replay("loop");
        done_cnt = 0;
        for (int i = 0; i < 10; i++) exp_rd.push_back((i % 4) * 2 + ((i % 4) == 3 ? 1 : 0));
        ack_n(10);
        chk("loop_still_en", m_en, 1);
        chk("loop_no_done", done_cnt, 0);
        chk("loop_addr", m_raddr, 2);
        send(P_MARK);
        chk("loop_stop_rec", m_ren, 1);
        chk("loop_stop_ovf", m_ovf, 0);
        chk("loop_stop_len", m_len_o, 0);

        chk("wr_left", exp_wr.size(), 0);
        chk("rd_left", exp_rd.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
